// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sdf_stage_ctrl
// Description : Per-stage controller for a radix-2 single-delay-feedback FFT
//               pipeline. Counts accepted input beats (not cycles) so input
//               stalls are tolerated, drains the delay line after the last
//               input beat, and lets the next frame's fill overlap the drain.
//               Drives mux select, shift enable, output valid and twiddle
//               ROM addressing.
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_stage_ctrl #(
    parameter int NFFT     = 64,
    parameter int STAGE_NO = 1,
    parameter int TW_W     = ($clog2(NFFT) > 1) ? ($clog2(NFFT) - 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_conv,
    input  logic                      in_valid,
    output logic                      sel1,
    output logic                      shift_en,
    output logic                      out_valid,
    output logic                      tw_en,
    output logic [TW_W-1:0]           tw_addr,
    output logic [$clog2(NFFT)-1:0]   sample_idx,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int c_LOG2N = $clog2(NFFT);
    localparam int c_D     = NFFT >> STAGE_NO;
    localparam int c_LD    = $clog2(c_D);
    localparam int c_TWSH  = STAGE_NO - 1;

    localparam logic [c_LOG2N-1:0] c_K_LAST = c_LOG2N'(NFFT - 1);
    localparam logic [c_LOG2N-1:0] c_K_FILL = c_LOG2N'(c_D - 1);
    localparam logic [c_LOG2N-1:0] c_ONE    = c_LOG2N'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]          r_state;
    logic [c_LOG2N-1:0]  r_k;
    logic [c_LOG2N-1:0]  r_o;
    logic                r_out_active;

    logic [1:0]          w_state_nxt;
    logic [c_LOG2N-1:0]  w_k_nxt;
    logic [c_LOG2N-1:0]  w_o_nxt;
    logic                w_out_active_nxt;

    logic                w_start_beat;
    logic                w_accept;
    logic [c_LOG2N-1:0]  w_acc_k;
    logic                w_shift_en;
    logic                w_sel1;
    logic                w_out_valid;
    logic                w_last_out;
    logic                w_fill_hit;
    logic [TW_W-1:0]     w_tw_addr;

    // Per-state decode: which beat is accepted (and its frame index), shift and mux select
    always_comb begin
        w_start_beat = start_conv && in_valid;
        w_accept     = 1'b0;
        w_acc_k      = '0;
        w_shift_en   = 1'b0;
        w_sel1       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_beat) begin
                    w_accept   = 1'b1;
                    w_shift_en = 1'b1;
                end
            end
            c_ST_RUN: begin
                // start_conv is deliberately not looked at while a frame is filling
                w_accept   = in_valid;
                w_shift_en = in_valid;
                w_acc_k    = r_k;
                w_sel1     = r_k[c_LD];
            end
            c_ST_FLUSH: begin
                // Drain runs every cycle; a start beat here begins the next frame at k=0
                w_shift_en = 1'b1;
                w_accept   = w_start_beat;
            end
            default: begin
                w_accept   = 1'b0;
            end
        endcase
        w_out_valid = w_shift_en && r_out_active;
        w_last_out  = w_out_valid && (r_o == c_K_LAST);
        w_fill_hit  = w_accept && (w_acc_k == c_K_FILL);
    end

    // Next-state, input counter, output counter and output-activity tracking
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        if (w_accept) begin
            if (w_acc_k == c_K_LAST) begin
                w_k_nxt     = '0;
                w_state_nxt = c_ST_FLUSH;
            end else begin
                w_k_nxt     = w_acc_k + c_ONE;
                w_state_nxt = c_ST_RUN;
            end
        end else if ((r_state == c_ST_FLUSH) && w_last_out) begin
            w_state_nxt = c_ST_IDLE;
        end else if ((r_state != c_ST_IDLE) && (r_state != c_ST_RUN) && (r_state != c_ST_FLUSH)) begin
            w_state_nxt = c_ST_IDLE;
        end

        w_o_nxt = w_out_valid ? (r_o + c_ONE) : r_o;

        // Set beats clear so a chained frame produces no gap in out_valid
        if (w_fill_hit) begin
            w_out_active_nxt = 1'b1;
        end else if (w_last_out) begin
            w_out_active_nxt = 1'b0;
        end else begin
            w_out_active_nxt = r_out_active;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_k          <= '0;
            r_o          <= '0;
            r_out_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_o          <= w_o_nxt;
            r_out_active <= w_out_active_nxt;
        end
    end

    // Twiddle address is (o mod D) shifted up by STAGE_NO-1, built bit by bit
    for (genvar b = 0; b < TW_W; b++) begin : g_tw_bit
        if ((b >= c_TWSH) && ((b - c_TWSH) < c_LD)) begin : g_map
            assign w_tw_addr[b] = r_o[b-c_TWSH];
        end else begin : g_zero
            assign w_tw_addr[b] = 1'b0;
        end
    end

    assign sel1       = w_sel1;
    assign shift_en   = w_shift_en;
    assign out_valid  = w_out_valid;
    assign frame_done = w_last_out;
    assign tw_en      = w_out_valid && r_o[c_LD];
    assign tw_addr    = w_tw_addr;
    assign sample_idx = r_k;
    assign busy       = (r_state != c_ST_IDLE) || r_out_active;

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdf_stage_ctrl
// Description : Self-checking bench for sdf_stage_ctrl. Three instances
//               (STAGE_NO 1, 2, 6 at NFFT=64) share one stimulus stream and
//               are compared each cycle against a delay-line model, plus
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_conv;
    logic in_valid;

    always #5 clk = ~clk;

    logic       sel1_a  [3];
    logic       shift_a [3];
    logic       ov_a    [3];
    logic       twe_a   [3];
    logic       busy_a  [3];
    logic       fd_a    [3];
    logic [4:0] twa_a   [3];
    logic [5:0] sidx_a  [3];

    sdf_stage_ctrl #(.NFFT(64), .STAGE_NO(1)) u_s1 (
        .clk(clk), .rst(rst), .start_conv(start_conv), .in_valid(in_valid),
        .sel1(sel1_a[0]), .shift_en(shift_a[0]), .out_valid(ov_a[0]), .tw_en(twe_a[0]),
        .tw_addr(twa_a[0]), .sample_idx(sidx_a[0]), .busy(busy_a[0]), .frame_done(fd_a[0])
    );
    sdf_stage_ctrl #(.NFFT(64), .STAGE_NO(2)) u_s2 (
        .clk(clk), .rst(rst), .start_conv(start_conv), .in_valid(in_valid),
        .sel1(sel1_a[1]), .shift_en(shift_a[1]), .out_valid(ov_a[1]), .tw_en(twe_a[1]),
        .tw_addr(twa_a[1]), .sample_idx(sidx_a[1]), .busy(busy_a[1]), .frame_done(fd_a[1])
    );
    sdf_stage_ctrl #(.NFFT(64), .STAGE_NO(6)) u_s6 (
        .clk(clk), .rst(rst), .start_conv(start_conv), .in_valid(in_valid),
        .sel1(sel1_a[2]), .shift_en(shift_a[2]), .out_valid(ov_a[2]), .tw_en(twe_a[2]),
        .tw_addr(twa_a[2]), .sample_idx(sidx_a[2]), .busy(busy_a[2]), .frame_done(fd_a[2])
    );

    int total = 0;
    int bad   = 0;

    int dd [3] = '{32, 16, 1};
    int ss [3] = '{1, 2, 6};

    // Model: a literal delay line of D slots holding frame sample indices (-1 = bubble)
    bit running [3];
    int kin     [3];
    int dl      [3][64];
    int ptr     [3];
    int nreal   [3];

    int ncyc = 0;
    bit ovh  [3][2048];
    bit fdh  [3][2048];
    bit selh [3][2048];
    int nv   [3] = '{0, 0, 0};
    int nfd  [3] = '{0, 0, 0};
    int ntw  [3] = '{0, 0, 0};

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", nm, inst, ncyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            running[i] = 1'b0;
            kin[i]     = 0;
            ptr[i]     = 0;
            nreal[i]   = 0;
            for (int j = 0; j < 64; j++) dl[i][j] = -1;
        end
    endtask

    // Called mid-cycle with inputs stable: compare every output, then advance the model
    task automatic model_cycle();
        int d, s, head, a;
        bit acc, shf, ov;
        for (int i = 0; i < 3; i++) begin
            d    = dd[i];
            s    = ss[i];
            acc  = (in_valid === 1'b1) && (running[i] || (start_conv === 1'b1));
            shf  = acc || (!running[i] && (nreal[i] > 0));
            head = dl[i][ptr[i]];
            ov   = shf && (head >= 0);

            chk("shift_en",   i, int'(shift_a[i]), int'(shf));
            chk("sel1",       i, int'(sel1_a[i]),  int'(running[i] && (((kin[i] / d) % 2) == 1)));
            chk("out_valid",  i, int'(ov_a[i]),    int'(ov));
            chk("frame_done", i, int'(fd_a[i]),    int'(ov && (head == 63)));
            chk("tw_en",      i, int'(twe_a[i]),   int'(ov && (((head / d) % 2) == 1)));
            chk("busy",       i, int'(busy_a[i]),  int'(running[i] || (nreal[i] > 0)));
            chk("sample_idx", i, int'(sidx_a[i]),  kin[i]);
            if (ov) chk("tw_addr", i, int'(twa_a[i]), ((head % d) << (s - 1)) % 32);

            if (ncyc < 2048) begin
                ovh[i][ncyc]  = ov_a[i];
                fdh[i][ncyc]  = fd_a[i];
                selh[i][ncyc] = sel1_a[i];
            end
            nv[i]  += int'(ov_a[i]);
            nfd[i] += int'(fd_a[i]);
            ntw[i] += int'(twe_a[i]);

            if (rst !== 1'b1) begin
                a = running[i] ? kin[i] : 0;
                if (shf) begin
                    if (head >= 0) nreal[i]--;
                    dl[i][ptr[i]] = acc ? a : -1;
                    if (acc) nreal[i]++;
                    ptr[i] = (ptr[i] + 1) % d;
                end
                if (acc) begin
                    if (a == 63) begin
                        running[i] = 1'b0;
                        kin[i]     = 0;
                    end else begin
                        running[i] = 1'b1;
                        kin[i]     = a + 1;
                    end
                end
            end
        end
        if (rst === 1'b1) model_reset();
        ncyc++;
    endtask

    task automatic step(input logic r, input logic s, input logic v);
        rst        = r;
        start_conv = s;
        in_valid   = v;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int ov_count(input int inst, input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) n += int'(ovh[inst][c]);
        return n;
    endfunction

    initial begin
        int c0, v0, f0, t0[3], fz[3];
        model_reset();

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_sel1",  i, int'(sel1_a[i]),  0);
            chk("rst_shift", i, int'(shift_a[i]), 0);
            chk("rst_ov",    i, int'(ov_a[i]),    0);
            chk("rst_busy",  i, int'(busy_a[i]),  0);
            chk("rst_fd",    i, int'(fd_a[i]),    0);
            chk("rst_twa",   i, int'(twa_a[i]),   0);
            chk("rst_sidx",  i, int'(sidx_a[i]),  0);
        end
        step(1'b0, 1'b0, 1'b0);
        // in_valid without start_conv is ignored
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("idle_sidx", 0, int'(sidx_a[0]), 0);
        chk("idle_busy", 0, int'(busy_a[0]), 0);

        // Single frame, in_valid held high
        c0 = ncyc; v0 = nv[0]; f0 = nfd[0];
        for (int i = 0; i < 3; i++) t0[i] = ntw[i];
        step(1'b0, 1'b1, 1'b1);
        repeat (63) step(1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0, 1'b0);
        chk("s1_sel_k31",    0, int'(selh[0][c0+31]), 0);
        chk("s1_sel_k32",    0, int'(selh[0][c0+32]), 1);
        chk("s1_ov_c31",     0, int'(ovh[0][c0+31]),  0);
        chk("s1_ov_c32",     0, int'(ovh[0][c0+32]),  1);
        chk("s1_ov_total",   0, nv[0] - v0, 64);
        chk("s1_flush_ovs",  0, ov_count(0, c0 + 64, c0 + 95), 32);
        chk("s1_fd_count",   0, nfd[0] - f0, 1);
        chk("s1_fd_at_64th", 0, int'(fdh[0][c0+95]), 1);
        chk("s1_busy_end",   0, int'(busy_a[0]), 0);
        chk("s6_ov_beat0",   2, int'(ovh[2][c0]),   0);
        chk("s6_ov_beat1",   2, int'(ovh[2][c0+1]), 1);
        for (int i = 0; i < 3; i++) chk("tw_en_count", i, ntw[i] - t0[i], 32);

        // in_valid toggling 1/0
        c0 = ncyc; v0 = nv[0]; f0 = nfd[0];
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        repeat (63) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        repeat (40) step(1'b0, 1'b0, 1'b0);
        chk("tog_sel_k31",   0, int'(selh[0][c0+62]), 0);
        chk("tog_sel_k32",   0, int'(selh[0][c0+64]), 1);
        chk("tog_flush_ovs", 0, ov_count(0, c0 + 127, c0 + 158), 32);
        chk("tog_after",     0, int'(ovh[0][c0+159]), 0);
        chk("tog_ov_total",  0, nv[0] - v0, 64);
        chk("tog_fd_count",  0, nfd[0] - f0, 1);

        // Chained frames: second start on the first FLUSH cycle
        c0 = ncyc; f0 = nfd[0];
        step(1'b0, 1'b1, 1'b1);
        repeat (63) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (63) step(1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0, 1'b0);
        chk("chn_ov_run",  0, ov_count(0, c0 + 32, c0 + 159), 128);
        chk("chn_ov_end",  0, int'(ovh[0][c0+160]), 0);
        chk("chn_fd_64",   0, int'(fdh[0][c0+95]),  1);
        chk("chn_fd_128",  0, int'(fdh[0][c0+159]), 1);
        chk("chn_fd_cnt",  0, nfd[0] - f0, 2);
        chk("chn_s6_run",  2, ov_count(2, c0 + 1, c0 + 128), 128);

        // start_conv mid-frame ignored, then reset at k=40
        for (int i = 0; i < 3; i++) fz[i] = nfd[i];
        step(1'b0, 1'b1, 1'b1);
        repeat (9) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("ign_start_sidx", 0, int'(sidx_a[0]), 11);
        repeat (29) step(1'b0, 1'b0, 1'b1);
        chk("pre_rst_sidx", 0, int'(sidx_a[0]), 40);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_ov",   i, int'(ov_a[i]),   0);
            chk("mid_rst_busy", i, int'(busy_a[i]), 0);
            chk("mid_rst_sidx", i, int'(sidx_a[i]), 0);
            chk("mid_rst_sel1", i, int'(sel1_a[i]), 0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) chk("mid_rst_no_fd", i, nfd[i] - fz[i], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
